// File: rtl/branch_pred_ctrl.sv
// ---------------------------------------------------------------------------
// branch_pred_ctrl
//
// Purpose:
//   This block is a bimodal branch predictor with mispredict recovery control.
//   - Prediction: it keeps a table of 2**IDX_W two-bit saturating counters,
//     indexed by pc[IDX_W+1:2]. The fetch stage receives a combinational
//     prediction for if_pc.
//   - Training: when a branch resolves in EX, the table is updated with the
//     real outcome.
//   - Recovery: on a mispredict, a small FSM spends exactly one cycle in
//     REDIRECT. During that cycle it raises redirect_valid and flush and
//     presents the corrected fetch PC. Any EX instruction seen during that
//     cycle is wrong-path and is ignored.
//   - Statistics: saturating counters track resolved branches and
//     mispredicts.
//
// Ports:
//   clk              in   clock; all state updates on the rising edge
//   rst              in   synchronous active-high reset
//   if_pc[31:0]      in   fetch PC to predict
//   if_pred_taken    out  prediction for if_pc (combinational table read)
//   ex_valid         in   EX instruction valid
//   ex_is_branch     in   EX instruction is a conditional branch
//   ex_stall         in   EX held this cycle; no resolution is taken
//   ex_pc[31:0]      in   PC of the EX branch
//   ex_target[31:0]  in   computed branch target
//   ex_pred_taken    in   prediction carried down the pipe with the branch
//   ex_branch_taken  in   actual branch outcome
//   redirect_valid   out  fetch redirect request (registered)
//   redirect_pc      out  corrected fetch PC (registered)
//   flush            out  squash wrong-path IF/ID/EX contents (registered)
//   branch_cnt       out  resolved-branch count (saturating)
//   mispred_cnt      out  mispredict count (saturating)
// ---------------------------------------------------------------------------
module branch_pred_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_stall,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        ex_branch_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int ENTRIES = 2 ** IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  bht_r [0:ENTRIES-1];

    logic [IDX_W-1:0] if_idx_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic             resolve_s;
    logic             mispredict_s;
    logic [1:0]       ex_cnt_s;
    logic [1:0]       ex_cnt_next_s;
    logic [31:0]      redirect_pc_next_s;

    logic             redirect_valid_r;
    logic             flush_r;
    logic [31:0]      redirect_pc_r;
    logic [31:0]      branch_cnt_r;
    logic [31:0]      mispred_cnt_r;

    // The word-offset and upper PC bits of the fetch address do not select a table entry
    logic unused_if_pc_s;
    assign unused_if_pc_s = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    assign if_idx_s = if_pc[IDX_W+1:2];
    assign ex_idx_s = ex_pc[IDX_W+1:2];

    // The prediction reads the stored counter; an update in this same cycle becomes visible next cycle
    assign if_pred_taken = bht_r[if_idx_s][1];

    // A branch is taken only in IDLE, so a wrong-path instruction in REDIRECT is ignored
    assign resolve_s    = ex_valid & ex_is_branch & ~ex_stall & (state_r == ST_IDLE);
    assign mispredict_s = resolve_s & (ex_pred_taken != ex_branch_taken);
    assign ex_cnt_s     = bht_r[ex_idx_s];

    // Compute the saturating counter update for the resolving branch's entry
    always_comb begin
        ex_cnt_next_s = ex_cnt_s;
        if (ex_branch_taken) begin
            if (ex_cnt_s != 2'b11) begin
                ex_cnt_next_s = ex_cnt_s + 2'd1;
            end else begin
                ex_cnt_next_s = ex_cnt_s;
            end
        end else begin
            if (ex_cnt_s != 2'b00) begin
                ex_cnt_next_s = ex_cnt_s - 2'd1;
            end else begin
                ex_cnt_next_s = ex_cnt_s;
            end
        end
    end

    // Select the corrected fetch PC: the target if taken, otherwise the fall-through (wraps at 2**32)
    always_comb begin
        redirect_pc_next_s = ex_pc + 32'd4;
        if (ex_branch_taken) begin
            redirect_pc_next_s = ex_target;
        end else begin
            redirect_pc_next_s = ex_pc + 32'd4;
        end
    end

    // Decide the recovery FSM next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mispredict_s) begin
                    state_next_s = ST_REDIRECT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REDIRECT: state_next_s = ST_IDLE;
            default:     state_next_s = ST_IDLE;
        endcase
    end

    // Register the FSM state and the redirect/flush outputs; rst takes priority over a mispredict
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            redirect_valid_r <= 1'b0;
            flush_r          <= 1'b0;
            redirect_pc_r    <= 32'h0000_0000;
        end else begin
            state_r          <= state_next_s;
            // The outputs are high exactly for the cycle spent in REDIRECT
            redirect_valid_r <= (state_next_s == ST_REDIRECT);
            flush_r          <= (state_next_s == ST_REDIRECT);
            if (mispredict_s) begin
                redirect_pc_r <= redirect_pc_next_s;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    // Train the table: on reset every entry is weak-not-taken, otherwise update the resolving entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (resolve_s) begin
            bht_r[ex_idx_s] <= ex_cnt_next_s;
        end else begin
            bht_r[ex_idx_s] <= bht_r[ex_idx_s];
        end
    end

    // Count resolved branches and mispredicts; both hold at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_r  <= 32'h0000_0000;
            mispred_cnt_r <= 32'h0000_0000;
        end else begin
            if (resolve_s && (branch_cnt_r != 32'hFFFF_FFFF)) begin
                branch_cnt_r <= branch_cnt_r + 32'd1;
            end else begin
                branch_cnt_r <= branch_cnt_r;
            end
            if (mispredict_s && (mispred_cnt_r != 32'hFFFF_FFFF)) begin
                mispred_cnt_r <= mispred_cnt_r + 32'd1;
            end else begin
                mispred_cnt_r <= mispred_cnt_r;
            end
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign flush          = flush_r;
    assign redirect_pc    = redirect_pc_r;
    assign branch_cnt     = branch_cnt_r;
    assign mispred_cnt    = mispred_cnt_r;

endmodule

// File: doc/branch_pred_ctrl.md
BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning branch history table (BHT) index width; table holds 2**IDX_W entries.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_pc  input  32  fetch-stage PC to predict.
REQ-005 SHALL have port if_pred_taken  output  1  prediction for if_pc (combinational).
REQ-006 SHALL have port ex_valid  input  1  EX-stage instruction valid.
REQ-007 SHALL have port ex_is_branch  input  1  EX instruction is a conditional branch.
REQ-008 SHALL have port ex_stall  input  1  EX held this cycle; no resolution is taken.
REQ-009 SHALL have port ex_pc  input  32  PC of EX branch.
REQ-010 SHALL have port ex_target  input  32  computed branch target.
REQ-011 SHALL have port ex_pred_taken  input  1  prediction carried down the pipe with the branch.
REQ-012 SHALL have port ex_branch_taken  input  1  actual outcome from the branch comparator.
REQ-013 SHALL have port redirect_valid  output  1  fetch redirect request.
REQ-014 SHALL have port redirect_pc  output  32  corrected fetch PC.
REQ-015 SHALL have port flush  output  1  squash IF/ID/EX wrong-path contents.
REQ-016 SHALL have port branch_cnt  output  32  resolved-branch count.
REQ-017 SHALL have port mispred_cnt  output  32  mispredict count.

Function
REQ-018 SHALL hold 2**IDX_W 2-bit saturating counters (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-019 SHALL index the BHT with pc[IDX_W+1:2] for both lookup and update.
REQ-020 SHALL drive if_pred_taken = bit 1 of the indexed counter, combinationally, with no bypass of a same-cycle update (old value read).
REQ-021 SHALL define resolve = ex_valid & ex_is_branch & ~ex_stall & (state == IDLE).
REQ-022 SHALL, on resolve, increment the ex_pc entry (saturate at 11) if ex_branch_taken, else decrement (saturate at 00); write visible from the next cycle.
REQ-023 SHALL define mispredict = resolve & (ex_pred_taken != ex_branch_taken).
REQ-024 SHALL implement FSM states IDLE and REDIRECT; IDLE->REDIRECT on mispredict; REDIRECT->IDLE unconditionally after one cycle.
REQ-025 SHALL assert redirect_valid and flush for exactly the one cycle spent in REDIRECT (one-cycle latency from mispredict), registered outputs.
REQ-026 SHALL register redirect_pc on mispredict as ex_target if ex_branch_taken, else ex_pc + 4 modulo 2**32; hold it otherwise.
REQ-027 SHALL ignore ex_valid in REDIRECT (wrong-path instruction): no BHT update, no count, no new mispredict.
REQ-028 SHALL increment branch_cnt on each resolve and mispred_cnt on each mispredict; both saturate at 0xFFFFFFFF.
REQ-029 SHALL take no action when ex_stall=1, even if the branch is valid; resolution occurs in the cycle stall drops.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, set all BHT entries to 01, state IDLE, redirect_valid=0, flush=0, redirect_pc=0, branch_cnt=0, mispred_cnt=0.
REQ-031 SHALL let rst override a same-cycle mispredict or REDIRECT state (redirect dropped, no update).

Verification
REQ-032 SHALL cover: after reset, if_pc=0x100 -> if_pred_taken=0; two resolves of ex_pc=0x100 taken, ex_pred_taken=0 then 1 -> entry 11, if_pred_taken=1, branch_cnt=2, mispred_cnt=1.
REQ-033 SHALL cover: mispredict ex_pc=0x200, ex_target=0x80, taken, pred 0 -> next cycle redirect_valid=1, flush=1, redirect_pc=0x80; following cycle both 0.
REQ-034 SHALL cover: mispredict not-taken at ex_pc=0xFFFFFFFC, pred 1 -> redirect_pc=0x00000000.
REQ-035 SHALL cover: valid branch in cycle after mispredict (REDIRECT) -> no counter/BHT change, no second redirect.
REQ-036 SHALL cover: valid branch with ex_stall=1 for 3 cycles then 0 -> exactly one resolve, branch_cnt +1.
REQ-037 SHALL cover: rst asserted in same cycle as mispredict -> redirect_valid stays 0, counters 0, entry back to 01.
